// File: rtl/inst_cache_req_arb.sv
// inst_cache_req_arb: shares the inst-cache request port between preIF fetch (id 0) and CACHE maintenance (id 1).
// Optional macro INST_ARB_RR_EN: round-robin tie-break instead of maintenance-first fixed priority.
module inst_cache_req_arb #(
    parameter int OUTS_DEPTH = 4,
    parameter int OUTS_AW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_req,
    input  logic        fs_uncache,
    input  logic [19:0] fs_tag,
    input  logic [7:0]  fs_index,
    input  logic [3:0]  fs_offset,
    output logic        fs_addr_ok,
    output logic        fs_data_ok,
    output logic [31:0] fs_rdata,
    input  logic        mt_req,
    input  logic [2:0]  mt_op,
    input  logic [19:0] mt_tag,
    input  logic [7:0]  mt_index,
    input  logic [3:0]  mt_offset,
    output logic        mt_addr_ok,
    output logic        mt_data_ok,
    input  logic        flush,
    output logic        ic_valid,
    output logic [2:0]  ic_op,
    output logic        ic_uncache,
    output logic [19:0] ic_tag,
    output logic [7:0]  ic_index,
    output logic [3:0]  ic_offset,
    input  logic        ic_addr_ok,
    input  logic        ic_data_ok,
    input  logic [31:0] ic_rdata
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

    localparam logic [OUTS_AW:0]   FULL_C    = (OUTS_AW+1)'(OUTS_DEPTH);
    localparam logic [OUTS_AW:0]   CNT_ONE_C = (OUTS_AW+1)'(1);
    localparam logic [OUTS_AW-1:0] PTR_ONE_C = OUTS_AW'(1);

    state_e             state_r, state_nxt_s;
    logic [OUTS_AW:0]   count_r;
    logic [OUTS_AW-1:0] wptr_r, rptr_r;
    logic               fifo_id_r     [OUTS_DEPTH];
    logic               fifo_cancel_r [OUTS_DEPTH];

    logic [2:0]  hold_op_r;
    logic        hold_uncache_r;
    logic [19:0] hold_tag_r;
    logic [7:0]  hold_index_r;
    logic [3:0]  hold_offset_r;
    logic        hold_id_r;
    logic        hold_cancel_r;

    logic        full_s, win_id_s, push_s, pop_s, head_id_s, head_cancel_s;
    logic        req_valid_s, req_id_s, req_cancel_s, req_uncache_s;
    logic [2:0]  req_op_s;
    logic [19:0] req_tag_s;
    logic [7:0]  req_index_s;
    logic [3:0]  req_offset_s;

`ifdef INST_ARB_RR_EN
    logic last_win_r;

    // Remember which requester was pushed last so the other one wins the next tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_win_r <= 1'b1;
        end else if (push_s) begin
            last_win_r <= req_id_s;
        end
    end
`endif

    assign full_s        = (count_r == FULL_C);
    assign head_id_s     = fifo_id_r[rptr_r];
    assign head_cancel_s = fifo_cancel_r[rptr_r];
    assign push_s        = req_valid_s & ic_addr_ok;
    assign pop_s         = ic_data_ok & (count_r != {(OUTS_AW+1){1'b0}});

    // Tie-break between the two requesters
    always_comb begin
        win_id_s = 1'b0;
        if (mt_req && fs_req) begin
`ifdef INST_ARB_RR_EN
            win_id_s = ~last_win_r;
`else
            win_id_s = 1'b1;
`endif
        end else if (mt_req) begin
            win_id_s = 1'b1;
        end else begin
            win_id_s = 1'b0;
        end
    end

    // Select the request currently presented to the cache: live winner in IDLE, held copy in HOLD
    always_comb begin
        req_valid_s   = 1'b0;
        req_id_s      = 1'b0;
        req_cancel_s  = 1'b0;
        req_op_s      = 3'b000;
        req_uncache_s = 1'b0;
        req_tag_s     = 20'h00000;
        req_index_s   = 8'h00;
        req_offset_s  = 4'h0;
        case (state_r)
            IDLE: begin
                if (!full_s && (fs_req || mt_req)) begin
                    req_valid_s = 1'b1;
                    req_id_s    = win_id_s;
                    if (win_id_s) begin
                        req_op_s     = mt_op;
                        req_tag_s    = mt_tag;
                        req_index_s  = mt_index;
                        req_offset_s = mt_offset;
                    end else begin
                        // a fetch granted during flush is already stale
                        req_uncache_s = fs_uncache;
                        req_tag_s     = fs_tag;
                        req_index_s   = fs_index;
                        req_offset_s  = fs_offset;
                        req_cancel_s  = flush;
                    end
                end else begin
                    req_valid_s = 1'b0;
                end
            end
            HOLD: begin
                req_valid_s   = 1'b1;
                req_id_s      = hold_id_r;
                req_op_s      = hold_op_r;
                req_uncache_s = hold_uncache_r;
                req_tag_s     = hold_tag_r;
                req_index_s   = hold_index_r;
                req_offset_s  = hold_offset_r;
                req_cancel_s  = hold_cancel_r | (flush & ~hold_id_r);
            end
            default: begin
                req_valid_s = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: park in HOLD while the cache has not accepted the granted request
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid_s && !ic_addr_ok) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if (ic_addr_ok) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: cache request and per-owner handshakes, forced low while reset is asserted
    always_comb begin
        ic_valid   = 1'b0;
        ic_op      = 3'b000;
        ic_uncache = 1'b0;
        ic_tag     = 20'h00000;
        ic_index   = 8'h00;
        ic_offset  = 4'h0;
        fs_addr_ok = 1'b0;
        mt_addr_ok = 1'b0;
        fs_data_ok = 1'b0;
        mt_data_ok = 1'b0;
        fs_rdata   = 32'h0000_0000;
        if (reset) begin
            ic_valid = 1'b0;
        end else begin
            ic_valid   = req_valid_s;
            ic_op      = req_op_s;
            ic_uncache = req_uncache_s;
            ic_tag     = req_tag_s;
            ic_index   = req_index_s;
            ic_offset  = req_offset_s;
            fs_addr_ok = push_s & ~req_id_s & ~req_cancel_s;
            mt_addr_ok = push_s & req_id_s;
            mt_data_ok = pop_s & head_id_s;
            fs_data_ok = pop_s & ~head_id_s & ~head_cancel_s & ~flush;
            if (fs_data_ok) begin
                fs_rdata = ic_rdata;
            end else begin
                fs_rdata = 32'h0000_0000;
            end
        end
    end

    // Hold register: captures the request on a refused grant and tracks flush while waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_op_r      <= 3'b000;
            hold_uncache_r <= 1'b0;
            hold_tag_r     <= 20'h00000;
            hold_index_r   <= 8'h00;
            hold_offset_r  <= 4'h0;
            hold_id_r      <= 1'b0;
            hold_cancel_r  <= 1'b0;
        end else if (req_valid_s && !ic_addr_ok) begin
            hold_op_r      <= req_op_s;
            hold_uncache_r <= req_uncache_s;
            hold_tag_r     <= req_tag_s;
            hold_index_r   <= req_index_s;
            hold_offset_r  <= req_offset_s;
            hold_id_r      <= req_id_s;
            hold_cancel_r  <= req_cancel_s;
        end
    end

    // Outstanding FIFO: in-order {id, cancel}; flush marks every queued fetch stale
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_r <= '0;
            rptr_r <= '0;
            for (int i = 0; i < OUTS_DEPTH; i++) begin
                fifo_id_r[i]     <= 1'b0;
                fifo_cancel_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < OUTS_DEPTH; i++) begin
                fifo_cancel_r[i] <= fifo_cancel_r[i] | (flush & ~fifo_id_r[i]);
            end
            if (push_s) begin
                fifo_id_r[wptr_r]     <= req_id_s;
                fifo_cancel_r[wptr_r] <= req_cancel_s;
                wptr_r                <= wptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE_C;
            end
        end
    end

    // Occupancy counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule
